// File: rtl/filter_ewma_sched.sv
// Multi-channel EWMA filter: one subtract/multiply/add datapath is time-shared round-robin
// across CHANNELS channels per sample frame, and all outputs are published together.
module filter_ewma_sched #(
  parameter int CHANNELS   = 4,
  parameter int DATA_BITS  = 12,
  parameter int ALPHA_BITS = 9
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             sample_tick,
  input  logic [CHANNELS*DATA_BITS-1:0]    din,
  input  logic [CHANNELS*ALPHA_BITS-1:0]   alpha,
  input  logic [CHANNELS-1:0]              chan_enable,
  output logic [CHANNELS*DATA_BITS-1:0]    dout,
  output logic                             dout_valid,
  output logic                             busy,
  output logic                             overrun
);

  localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int SUM_W  = DATA_BITS + 1;
  localparam int PROD_W = DATA_BITS + ALPHA_BITS + 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNELS - 1);

  typedef enum logic [1:0] {IDLE, CALC, WRITE, DONE} state_t;

  state_t                       state, state_nxt;
  logic [CH_W-1:0]              ch;

  logic signed [DATA_BITS-1:0]  x_snap [CHANNELS];
  logic signed [ALPHA_BITS-1:0] a_snap [CHANNELS];
  logic [CHANNELS-1:0]          en_snap;
  logic signed [DATA_BITS-1:0]  y [CHANNELS];
  logic signed [PROD_W-1:0]     prod_p1;

  logic signed [DATA_BITS-1:0]  x_cur, y_cur, y_new;
  logic signed [ALPHA_BITS-1:0] a_cur;
  logic signed [SUM_W-1:0]      diff_p0, step_p1, sum_p1;
  logic signed [PROD_W-1:0]     prod_p0;

  function automatic logic signed [ALPHA_BITS-1:0] clamp_alpha(
    input logic signed [ALPHA_BITS-1:0] a
  );
    return a[ALPHA_BITS-1] ? '0 : a;
  endfunction

  function automatic logic signed [DATA_BITS-1:0] sat(input logic signed [SUM_W-1:0] v);
    if (v[SUM_W-1] != v[SUM_W-2])
      return v[SUM_W-1] ? {1'b1, {(DATA_BITS-1){1'b0}}} : {1'b0, {(DATA_BITS-1){1'b1}}};
    return v[DATA_BITS-1:0];
  endfunction

  // Stage p0 (CALC): error times alpha; stage p1 (WRITE): floor-scaled step added to state
  always_comb begin
    x_cur   = x_snap[ch];
    y_cur   = y[ch];
    a_cur   = clamp_alpha(a_snap[ch]);
    diff_p0 = SUM_W'(x_cur) - SUM_W'(y_cur);
    prod_p0 = PROD_W'(diff_p0) * PROD_W'(a_cur);
    step_p1 = SUM_W'(prod_p1 >>> 8);
    sum_p1  = SUM_W'(y_cur) + step_p1;
    y_new   = en_snap[ch] ? sat(sum_p1) : y_cur;
  end

  // Frame snapshot and product register carry no reset; they are always written before use
  always_ff @(posedge clk) begin
    if (state == IDLE && sample_tick) begin
      for (int c = 0; c < CHANNELS; c++) begin
        x_snap[c] <= din[c*DATA_BITS +: DATA_BITS];
        a_snap[c] <= alpha[c*ALPHA_BITS +: ALPHA_BITS];
      end
      en_snap <= chan_enable;
    end
    if (state == CALC)
      prod_p1 <= prod_p0;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sample_tick) state_nxt = CALC;
      CALC:    state_nxt = WRITE;
      WRITE:   state_nxt = (ch == LAST_CH) ? DONE : CALC;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // dout is loaded on the edge that writes the last channel, so the DONE cycle carries valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ch      <= '0;
      overrun <= 1'b0;
      dout    <= '0;
      for (int c = 0; c < CHANNELS; c++)
        y[c] <= '0;
    end else begin
      state   <= state_nxt;
      overrun <= sample_tick && (state != IDLE);
      case (state)
        IDLE: if (sample_tick) ch <= '0;
        WRITE: begin
          y[ch] <= y_new;
          if (ch == LAST_CH) begin
            for (int c = 0; c < CHANNELS; c++)
              dout[c*DATA_BITS +: DATA_BITS] <= (CH_W'(c) == ch) ? y_new : y[c];
          end else begin
            ch <= ch + CH_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy       = (state != IDLE);
  assign dout_valid = (state == DONE);

endmodule
